// File: rtl/proyecto_top.sv
// proyecto_top: 24-hour time-of-day core driven by a 1 Hz prescaler tick.
// Ports:
//   clk       system clock, all state updates on the rising edge
//   rst_n     asynchronous active-low reset
//   run       1 = prescaler and time fields advance, 0 = frozen
//   set_en    load strobe for the field chosen by set_sel
//   set_sel   0 = seconds, 1 = minutes, 2 = hours, 3 = no-op
//   set_value value to load, clamped to the field maximum
//   value1    seconds 0..59
//   value2    minutes 0..59
//   value3    hours 0..23
//   tick      one-cycle pulse coincident with each seconds advance
module proyecto_top #(
  parameter int         CLK_HZ = 25_000_000,
  parameter logic [5:0] INIT   = 6'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic [5:0] set_value,
  output logic [5:0] value1,
  output logic [5:0] value2,
  output logic [5:0] value3,
  output logic       tick
);
  localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TC = PW'(CLK_HZ - 1);
  logic [PW-1:0] pre;
  logic          load;
  logic          wrap;
  logic          s_max;
  logic          m_max;
  logic          h_max;
  logic [5:0]    lim59;
  logic [5:0]    lim23;
  assign load  = set_en && set_sel != 2'd3;
  assign wrap  = run && pre == TC;
  assign s_max = value1 == 6'd59;
  assign m_max = value2 == 6'd59;
  assign h_max = value3 == 6'd23;
  assign lim59 = set_value > 6'd59 ? 6'd59 : set_value;
  assign lim23 = set_value > 6'd23 ? 6'd23 : set_value;
  // A load takes priority over a coincident wrap: no carry, no tick, and the
  // prescaler restarts so the following second is a full period.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre    <= '0;
      value1 <= '0;
      value2 <= '0;
      value3 <= INIT;
      tick   <= 1'b0;
    end else begin
      tick <= wrap && !load;
      if (load || wrap) pre <= '0;
      else if (run) pre <= pre + 1'b1;
      if (load) begin
        if (set_sel == 2'd0) value1 <= lim59;
        if (set_sel == 2'd1) value2 <= lim59;
        if (set_sel == 2'd2) value3 <= lim23;
      end else if (wrap) begin
        value1 <= s_max ? 6'd0 : value1 + 1'b1;
        if (s_max) value2 <= m_max ? 6'd0 : value2 + 1'b1;
        if (s_max && m_max) value3 <= h_max ? 6'd0 : value3 + 1'b1;
      end
    end
endmodule

// File: tb/tb_proyecto_top.sv
// tb_proyecto_top: table-driven and scoreboard check of the time-of-day core.
module tb_proyecto_top;
  localparam int CLK_HZ = 4;
  logic       clk;
  logic       rst_n;
  logic       run;
  logic       set_en;
  logic [1:0] set_sel;
  logic [5:0] set_value;
  logic [5:0] value1;
  logic [5:0] value2;
  logic [5:0] value3;
  logic       tick;
  int checks;
  int errors;
  int tod;
  int pre;
  logic mt;
  typedef struct {
    logic [5:0] v1;
    logic [5:0] v2;
    logic [5:0] v3;
    logic       t;
  } exp_t;
  exp_t q[$];
  typedef struct {
    logic       run;
    logic       se;
    logic [1:0] sel;
    logic [5:0] val;
    int         n;
    logic [5:0] e1;
    logic [5:0] e2;
    logic [5:0] e3;
  } vec_t;
  vec_t tbl[14];
  proyecto_top #(.CLK_HZ(CLK_HZ), .INIT(6'd1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .set_en(set_en),
    .set_sel(set_sel),
    .set_value(set_value),
    .value1(value1),
    .value2(value2),
    .value3(value3),
    .tick(tick)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    end
  endtask
  task automatic model(input logic r, input logic se, input logic [1:0] sl, input logic [5:0] v);
    int h, m, s;
    h = tod / 3600;
    m = (tod / 60) % 60;
    s = tod % 60;
    if (se && sl != 2'd3) begin
      if (sl == 2'd0) s = v > 59 ? 59 : int'(v);
      if (sl == 2'd1) m = v > 59 ? 59 : int'(v);
      if (sl == 2'd2) h = v > 23 ? 23 : int'(v);
      tod = h * 3600 + m * 60 + s;
      pre = 0;
      mt = 1'b0;
    end else if (r) begin
      if (pre == CLK_HZ - 1) begin
        pre = 0;
        tod = (tod + 1) % 86400;
        mt = 1'b1;
      end else begin
        pre++;
        mt = 1'b0;
      end
    end else mt = 1'b0;
  endtask
  task automatic step(input logic r, input logic se, input logic [1:0] sl, input logic [5:0] v);
    exp_t e;
    run = r;
    set_en = se;
    set_sel = sl;
    set_value = v;
    model(r, se, sl, v);
    e = '{6'(tod % 60), 6'((tod / 60) % 60), 6'(tod / 3600), mt};
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = q.pop_front();
    chk("sb", checks, 32'({value3, value2, value1, tick}), 32'({e.v3, e.v2, e.v1, e.t}));
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    run = 1'b0;
    set_en = 1'b0;
    set_sel = 2'd0;
    set_value = 6'd0;
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 6'd0,  40, 6'd10, 6'd0,  6'd1};
    tbl[1]  = '{1'b1, 1'b1, 2'd0, 6'd59, 1,  6'd59, 6'd0,  6'd1};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 6'd0,  4,  6'd0,  6'd1,  6'd1};
    tbl[3]  = '{1'b0, 1'b1, 2'd2, 6'd23, 1,  6'd0,  6'd1,  6'd23};
    tbl[4]  = '{1'b0, 1'b1, 2'd1, 6'd59, 1,  6'd0,  6'd59, 6'd23};
    tbl[5]  = '{1'b0, 1'b1, 2'd0, 6'd59, 1,  6'd59, 6'd59, 6'd23};
    tbl[6]  = '{1'b1, 1'b0, 2'd0, 6'd0,  4,  6'd0,  6'd0,  6'd0};
    tbl[7]  = '{1'b0, 1'b1, 2'd1, 6'd63, 1,  6'd0,  6'd59, 6'd0};
    tbl[8]  = '{1'b0, 1'b1, 2'd2, 6'd40, 1,  6'd0,  6'd59, 6'd23};
    tbl[9]  = '{1'b0, 1'b1, 2'd3, 6'd17, 1,  6'd0,  6'd59, 6'd23};
    tbl[10] = '{1'b0, 1'b1, 2'd0, 6'd60, 1,  6'd59, 6'd59, 6'd23};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 6'd0,  2,  6'd59, 6'd59, 6'd23};
    tbl[12] = '{1'b0, 1'b0, 2'd0, 6'd0,  20, 6'd59, 6'd59, 6'd23};
    tbl[13] = '{1'b1, 1'b0, 2'd0, 6'd0,  2,  6'd0,  6'd0,  6'd0};
    repeat (3) @(negedge clk);
    chk("reset", 0, 32'({value3, value2, value1, tick}), 32'({6'd1, 6'd0, 6'd0, 1'b0}));
    rst_n = 1'b1;
    tod = 3600;
    pre = 0;
    mt = 1'b0;
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < tbl[i].n; k++)
        step(tbl[i].run, k == 0 ? tbl[i].se : 1'b0, tbl[i].sel, tbl[i].val);
      chk("row", i, 32'({value3, value2, value1}), 32'({tbl[i].e3, tbl[i].e2, tbl[i].e1}));
    end
    repeat (3) step(1'b1, 1'b0, 2'd0, 6'd0);
    step(1'b1, 1'b1, 2'd1, 6'd63);
    chk("prio_tick", 0, 32'(tick), 32'(0));
    chk("prio_val", 0, 32'({value3, value2, value1}), 32'({6'd0, 6'd59, 6'd0}));
    repeat (3) step(1'b1, 1'b0, 2'd0, 6'd0);
    chk("prio_full", 0, 32'({tick, value1}), 32'({1'b0, 6'd0}));
    step(1'b1, 1'b0, 2'd0, 6'd0);
    chk("prio_next", 0, 32'({tick, value1}), 32'({1'b1, 6'd1}));
    step(1'b0, 1'b1, 2'd2, 6'd12);
    step(1'b0, 1'b1, 2'd1, 6'd34);
    step(1'b0, 1'b1, 2'd0, 6'd56);
    chk("load", 0, 32'({value3, value2, value1}), 32'({6'd12, 6'd34, 6'd56}));
    repeat (2) step(1'b1, 1'b0, 2'd0, 6'd0);
    #1 rst_n = 1'b0;
    #1 chk("async", 0, 32'({value3, value2, value1, tick}), 32'({6'd1, 6'd0, 6'd0, 1'b0}));
    @(posedge clk);
    @(negedge clk);
    chk("async_hold", 0, 32'({value3, value2, value1, tick}), 32'({6'd1, 6'd0, 6'd0, 1'b0}));
    rst_n = 1'b1;
    tod = 3600;
    pre = 0;
    repeat (3) step(1'b1, 1'b0, 2'd0, 6'd0);
    chk("restart_wait", 0, 32'({tick, value1}), 32'({1'b0, 6'd0}));
    step(1'b1, 1'b0, 2'd0, 6'd0);
    chk("restart_tick", 0, 32'({tick, value1}), 32'({1'b1, 6'd1}));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
